// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter_if
//  Description : Bus bundle between two requesting masters, the arbiter and
//                a synchronous slave memory / memory-mapped IO port.
//                "slave" is the arbiter's view (it serves the masters and
//                drives the slave bus); "master" is the environment's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    // Master 0 request side
    logic              m0_req;
    logic              m0_wen;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    // Master 1 request side
    logic              m1_req;
    logic              m1_wen;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    // Slave bus
    logic              En;
    logic              Wen;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;

    modport slave (
        input  m0_req, m0_wen, m0_addr, m0_wdata, m0_lock,
        input  m1_req, m1_wen, m1_addr, m1_wdata, m1_lock,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output En, Wen, addr_out, data_write,
        input  data_read
    );

    modport master (
        output m0_req, m0_wen, m0_addr, m0_wdata, m0_lock,
        output m1_req, m1_wen, m1_addr, m1_wdata, m1_lock,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  En, Wen, addr_out, data_write,
        output data_read
    );

endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Two-master round-robin arbiter in front of a synchronous
//                slave (one transfer every two cycles: ISSUE then RESP).
//                Optional bus locking is compiled in with macro ARB_LOCK_EN;
//                without it the m*_lock inputs are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_owner;        // master currently / last served
    logic              w_owner_next;
    logic              r_wen;          // direction of the transfer in flight
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    logic              w_req_any;
    logic              w_req_own;
    logic              w_rr_owner;
    logic              w_own_wen;
    logic [ADDR_W-1:0] w_own_addr;
    logic [DATA_W-1:0] w_own_wdata;
    logic              w_hold_idle;    // owner keeps the bus while idle
    logic              w_hold_resp;    // owner keeps the bus after this RESP

    logic              w_en;
    logic              w_wen;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_ack0;
    logic              w_ack1;

    assign w_req_any   = bus.m0_req | bus.m1_req;
    assign w_req_own   = r_owner ? bus.m1_req   : bus.m0_req;
    assign w_own_wen   = r_owner ? bus.m1_wen   : bus.m0_wen;
    assign w_own_addr  = r_owner ? bus.m1_addr  : bus.m0_addr;
    assign w_own_wdata = r_owner ? bus.m1_wdata : bus.m0_wdata;

    // On a tie the master not served last wins; a lone requester always wins.
    // Coming out of RESP this also gives the other master priority.
    assign w_rr_owner = (bus.m0_req & bus.m1_req) ? ~r_owner : bus.m1_req;

`ifdef ARB_LOCK_EN
    logic r_locked;
    logic w_lock_own;

    assign w_lock_own  = r_owner ? bus.m1_lock : bus.m0_lock;
    assign w_hold_idle = r_locked;
    assign w_hold_resp = w_lock_own;

    // Lock state is decided by the owner's lock input in its RESP cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_locked <= 1'b0;
        end else if (r_state == S_RESP) begin
            r_locked <= w_lock_own;
        end
    end
`else
    logic w_lock_unused;

    assign w_lock_unused = bus.m0_lock | bus.m1_lock;
    assign w_hold_idle   = 1'b0;
    assign w_hold_resp   = 1'b0;
`endif

    // State and owner registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
        end
    end

    // Next-state selection and bus/ack outputs
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_en         = 1'b0;
        w_wen        = 1'b0;
        w_addr       = '0;
        w_wdata      = '0;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_hold_idle) begin
                    if (w_req_own) begin
                        w_state_next = S_ISSUE;
                    end
                end else if (w_req_any) begin
                    w_state_next = S_ISSUE;
                    w_owner_next = w_rr_owner;
                end
            end
            S_ISSUE: begin
                w_en         = 1'b1;
                w_wen        = w_own_wen;
                w_addr       = w_own_addr;
                w_wdata      = w_own_wdata;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                // A reset landing in this cycle aborts the transfer: no ack
                w_ack0 = ~r_owner & ~reset;
                w_ack1 =  r_owner & ~reset;
                if (w_hold_resp) begin
                    w_state_next = w_req_own ? S_ISSUE : S_IDLE;
                end else if (w_req_any) begin
                    w_state_next = S_ISSUE;
                    w_owner_next = w_rr_owner;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture transfer direction and hold read data until the next read ack
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wen    <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_wen <= w_own_wen;
            end
            if (w_ack0 && !r_wen) begin
                r_rdata0 <= bus.data_read;
            end
            if (w_ack1 && !r_wen) begin
                r_rdata1 <= bus.data_read;
            end
        end
    end

    assign bus.En         = w_en;
    assign bus.Wen        = w_wen;
    assign bus.addr_out   = w_addr;
    assign bus.data_write = w_wdata;
    assign bus.m0_ack     = w_ack0;
    assign bus.m1_ack     = w_ack1;

    // Slave data is only valid in the ack cycle, so pass it straight through
    // there and serve the held copy afterwards.
    assign bus.m0_rdata = (w_ack0 && !r_wen) ? bus.data_read : r_rdata0;
    assign bus.m1_rdata = (w_ack1 && !r_wen) ? bus.data_read : r_rdata1;

endmodule
`default_nettype wire
